// File: rtl/avr_instruction_encoder.sv
// Encodes one AVR instruction per request into 1-2 program-memory words, first word 1 cycle after accept.
// Each word is held stable on word_valid until word_ready; req_ready is high only while idle.
module avr_instruction_encoder #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_value,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [7:0]        req_opcode,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rr,
   input  logic [21:0]       req_imm,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [15:0]       word_data,
   output logic [ADDR_W-1:0] word_addr,
   output logic              word_last,
   output logic              err,
   output logic              busy
);

   localparam logic [7:0] OP_LDI  = 8'd1;
   localparam logic [7:0] OP_JMP  = 8'd2;
   localparam logic [7:0] OP_CALL = 8'd3;
   localparam logic [7:0] OP_OUT  = 8'd4;
   localparam logic [7:0] OP_RET  = 8'd5;
   localparam logic [7:0] OP_CLI  = 8'd6;
   localparam logic [7:0] OP_RJMP = 8'd7;
   localparam logic [7:0] OP_EOR  = 8'd8;
   localparam logic [7:0] OP_SUBI = 8'd9;
   localparam logic [7:0] OP_SBCI = 8'd10;
   localparam logic [7:0] OP_BRNE = 8'd11;
   localparam logic [7:0] OP_NOP  = 8'd12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WORD0 = 2'd1,
      WORD1 = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr_cnt;
   logic [15:0]       lo_word_q;
   logic              two_word_q;

   logic [15:0]       enc_word;
   logic              enc_two;
   logic              req_legal;
   logic              req_accept;
   logic              req_reject;

   // Immediate-register forms only reach r16..r31, so d-16 is simply rd[3:0].
   always_comb begin
      enc_word  = 16'h0000;
      enc_two   = 1'b0;
      req_legal = 1'b1;
      case (req_opcode)
         OP_LDI: begin
            enc_word  = {4'b1110, req_imm[7:4], req_rd[3:0], req_imm[3:0]};
            req_legal = req_rd[4];
         end
         OP_SUBI: begin
            enc_word  = {4'b0101, req_imm[7:4], req_rd[3:0], req_imm[3:0]};
            req_legal = req_rd[4];
         end
         OP_SBCI: begin
            enc_word  = {4'b0100, req_imm[7:4], req_rd[3:0], req_imm[3:0]};
            req_legal = req_rd[4];
         end
         OP_JMP: begin
            enc_word = {4'b1001, 3'b010, req_imm[21:17], 3'b110, req_imm[16]};
            enc_two  = 1'b1;
         end
         OP_CALL: begin
            enc_word = {4'b1001, 3'b010, req_imm[21:17], 3'b111, req_imm[16]};
            enc_two  = 1'b1;
         end
         OP_OUT:  enc_word = {4'b1011, 1'b1, req_imm[5:4], req_rd, req_imm[3:0]};
         OP_RET:  enc_word = 16'h9508;
         OP_CLI:  enc_word = 16'h94F8;
         OP_RJMP: enc_word = {4'b1100, req_imm[11:0]};
         OP_EOR:  enc_word = {6'b001001, req_rr[4], req_rd, req_rr[3:0]};
         OP_BRNE: enc_word = {6'b111101, req_imm[6:0], 3'b001};
         OP_NOP:  enc_word = 16'h0000;
         default: req_legal = 1'b0;
      endcase
   end

   assign req_accept = (state == IDLE) && req_valid && req_legal;
   assign req_reject = (state == IDLE) && req_valid && !req_legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_accept) state_nxt = WORD0;
         WORD0:   if (word_ready) state_nxt = two_word_q ? WORD1 : IDLE;
         WORD1:   if (word_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A same-cycle addr_load lands before the request's first word, since the
   // counter is only read as word_addr from WORD0 onwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_cnt   <= '0;
         word_data  <= 16'h0000;
         word_last  <= 1'b0;
         err        <= 1'b0;
         lo_word_q  <= 16'h0000;
         two_word_q <= 1'b0;
      end else begin
         err <= req_reject;
         case (state)
            IDLE: begin
               if (addr_load) begin
                  addr_cnt <= addr_value;
               end
               if (req_accept) begin
                  word_data  <= enc_word;
                  word_last  <= !enc_two;
                  two_word_q <= enc_two;
                  lo_word_q  <= req_imm[15:0];
               end
            end
            WORD0: begin
               if (word_ready) begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
                  if (two_word_q) begin
                     word_data <= lo_word_q;
                     word_last <= 1'b1;
                  end
               end
            end
            WORD1: begin
               if (word_ready) begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign word_valid = (state != IDLE);
   assign busy       = (state != IDLE);
   assign req_ready  = (state == IDLE) && !reset;
   assign word_addr  = addr_cnt;

endmodule

// File: tb/tb_avr_instruction_encoder.sv
// Randomized self-checking bench for avr_instruction_encoder against an arithmetic reference model.
module tb_avr_instruction_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        addr_load = 1'b0;
   logic [15:0] addr_value = 16'h0000;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [7:0]  req_opcode = 8'd0;
   logic [4:0]  req_rd = 5'd0;
   logic [4:0]  req_rr = 5'd0;
   logic [21:0] req_imm = 22'd0;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic [15:0] word_data;
   logic [15:0] word_addr;
   logic        word_last;
   logic        err;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int m_addr = 0;

   avr_instruction_encoder #(.ADDR_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr_load  (addr_load),
      .addr_value (addr_value),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_rd     (req_rd),
      .req_rr     (req_rr),
      .req_imm    (req_imm),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .word_addr  (word_addr),
      .word_last  (word_last),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_legal(input int op, input int rd);
      if (op < 1 || op > 12) return 1'b0;
      if ((op == 1 || op == 9 || op == 10) && rd < 16) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int model_nwords(input int op);
      return (op == 2 || op == 3) ? 2 : 1;
   endfunction

   // Builds each word by adding field values scaled to their bit positions.
   function automatic logic [15:0] model_word(input int op, input int rd, input int rr,
                                              input int imm, input int idx);
      int k = imm % 256;
      int d = (rd - 16) % 16;
      int a = imm % 64;
      case (op)
         1:  return 16'(32'hE000 + (k / 16) * 256 + d * 16 + k % 16);
         9:  return 16'(32'h5000 + (k / 16) * 256 + d * 16 + k % 16);
         10: return 16'(32'h4000 + (k / 16) * 256 + d * 16 + k % 16);
         2, 3: begin
            if (idx == 1) return 16'(imm % 65536);
            return 16'(32'h940C + ((op == 3) ? 2 : 0) + ((imm / 131072) % 32) * 16
                       + (imm / 65536) % 2);
         end
         4:  return 16'(32'hB800 + (a / 16) * 512 + rd * 16 + a % 16);
         5:  return 16'h9508;
         6:  return 16'h94F8;
         7:  return 16'(32'hC000 + imm % 4096);
         8:  return 16'(32'h2400 + (rr / 16) * 512 + rd * 16 + rr % 16);
         11: return 16'(32'hF401 + (imm % 128) * 8);
         default: return 16'h0000;
      endcase
   endfunction

   // Entered and left one time unit after a rising edge with the DUT idle.
   task automatic do_req(input int op, input int rd, input int rr, input int imm,
                         input bit ld, input int ldv, input int stall0);
      int n;
      int st;
      check("idle_rdy", 32'(req_ready), 1);
      check("idle_vld", 32'(word_valid), 0);
      addr_load  = ld;
      addr_value = 16'(ldv);
      req_valid  = 1'b1;
      req_opcode = 8'(op);
      req_rd     = 5'(rd);
      req_rr     = 5'(rr);
      req_imm    = 22'(imm);
      @(posedge clk); #1;
      addr_load = 1'b0;
      req_valid = 1'b0;
      if (ld) m_addr = ldv % 65536;
      if (!model_legal(op, rd)) begin
         check("rej_err", 32'(err), 1);
         check("rej_vld", 32'(word_valid), 0);
         @(posedge clk); #1;
         check("rej_err_end", 32'(err), 0);
         check("rej_vld2", 32'(word_valid), 0);
         check("rej_addr", 32'(word_addr), 32'(m_addr));
         return;
      end
      check("acc_err", 32'(err), 0);
      n = model_nwords(op);
      for (int i = 0; i < n; i++) begin
         st = (i == 0) ? stall0 : int'($urandom_range(0, 2));
         for (int s = 0; s < st; s++) begin
            check("stall_vld", 32'(word_valid), 1);
            check("stall_dat", 32'(word_data), 32'(model_word(op, rd, rr, imm, i)));
            check("stall_adr", 32'(word_addr), 32'(m_addr));
            check("stall_rdy", 32'(req_ready), 0);
            @(posedge clk); #1;
         end
         check("w_vld", 32'(word_valid), 1);
         check("w_dat", 32'(word_data), 32'(model_word(op, rd, rr, imm, i)));
         check("w_adr", 32'(word_addr), 32'(m_addr));
         check("w_last", 32'(word_last), (i == n - 1) ? 1 : 0);
         check("w_busy", 32'(busy), 1);
         word_ready = 1'b1;
         @(posedge clk); #1;
         word_ready = 1'b0;
         m_addr = (m_addr + 1) % 65536;
      end
      check("end_vld", 32'(word_valid), 0);
      check("end_rdy", 32'(req_ready), 1);
      check("end_busy", 32'(busy), 0);
   endtask

   initial begin
      int op;
      int ldv;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vld", 32'(word_valid), 0);
      check("rst_dat", 32'(word_data), 0);
      check("rst_adr", 32'(word_addr), 0);
      check("rst_last", 32'(word_last), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      reset = 1'b0;
      #1;
      check("rst_rdy", 32'(req_ready), 1);
      @(posedge clk); #1;

      do_req(1, 16, 0, 32'hFF, 1'b1, 0, 0);
      do_req(2, 0, 0, 32'h34, 1'b1, 0, 0);
      do_req(3, 0, 0, 32'h3FFFFF, 1'b0, 0, 1);
      do_req(4, 0, 0, 32'h3F, 1'b0, 0, 3);
      do_req(11, 0, 0, 32'h3FFFFE, 1'b0, 0, 0);
      do_req(7, 0, 0, 32'h3FFFFF, 1'b0, 0, 0);
      do_req(8, 1, 1, 0, 1'b0, 0, 0);
      do_req(5, 0, 0, 0, 1'b0, 0, 0);
      do_req(6, 0, 0, 0, 1'b0, 0, 0);
      do_req(12, 0, 0, 0, 1'b0, 0, 0);
      do_req(0, 0, 0, 0, 1'b0, 0, 0);
      do_req(13, 0, 0, 0, 1'b0, 0, 0);
      do_req(1, 5, 0, 32'h12, 1'b0, 0, 0);
      do_req(2, 0, 0, 32'h1234, 1'b1, 32'hFFFF, 1);

      for (int it = 0; it < 300; it++) begin
         op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 255))
                                           : int'($urandom_range(0, 12));
         ldv = ($urandom_range(0, 3) == 0) ? 32'hFFFF : int'($urandom_range(0, 65535));
         do_req(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 32'h3FFFFF)), ($urandom_range(0, 7) == 0), ldv,
                int'($urandom_range(0, 2)));
      end

      // Abort a JMP while its second word sits at the wrapped address.
      addr_load  = 1'b1;
      addr_value = 16'hFFFF;
      req_valid  = 1'b1;
      req_opcode = 8'd2;
      req_imm    = 22'h000034;
      @(posedge clk); #1;
      addr_load = 1'b0;
      req_valid = 1'b0;
      check("ab_w0_adr", 32'(word_addr), 32'hFFFF);
      check("ab_w0_dat", 32'(word_data), 32'h940C);
      word_ready = 1'b1;
      @(posedge clk); #1;
      word_ready = 1'b0;
      check("ab_w1_vld", 32'(word_valid), 1);
      check("ab_w1_adr", 32'(word_addr), 0);
      check("ab_w1_dat", 32'(word_data), 32'h0034);
      #2;
      reset = 1'b1;
      #1;
      check("ab_async_vld", 32'(word_valid), 0);
      check("ab_async_busy", 32'(busy), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("ab_adr", 32'(word_addr), 0);
      repeat (2) begin
         @(posedge clk); #1;
         check("ab_quiet_vld", 32'(word_valid), 0);
         check("ab_rdy", 32'(req_ready), 1);
      end
      m_addr = 0;
      do_req(9, 31, 0, 32'hA5, 1'b0, 0, 0);
      do_req(10, 16, 0, 32'h5A, 1'b0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avr_instruction_encoder.md
Name: avr_instruction_encoder

Overview:
- Inverse of the core's opcode decoder. Accepts an opcode ID from the decoder's ID space plus operands, and produces the matching 16-bit AVR machine word or words.
- Streams the words, with sequential program-memory addresses, to the program-memory write port. Used by the debugger to patch or inject code.
- JMP and CALL produce two words; all other supported opcodes produce one.
- Unsupported IDs and illegal operands raise an error pulse and emit nothing.

Parameters:
- ADDR_W, 16, width of the program-memory word address and of the address counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- addr_load, input, 1, loads the address counter from addr_value. Honoured only in IDLE; ignored otherwise.
- addr_value, input, ADDR_W, new base address.
- req_valid, input, 1, encode request present.
- req_ready, output, 1, high only in IDLE.
- req_opcode, input, 8, opcode ID: error=0, ldi=1, jmp=2, call=3, out=4, ret=5, cli=6, rjmp=7, eor=8, subi=9, sbci=10, brne=11, nop=12.
- req_rd, input, 5, destination register; also the source register r for OUT.
- req_rr, input, 5, source register for EOR.
- req_imm, input, 22, immediate, I/O address, relative offset or absolute address.
- word_valid, output, 1, word_data and word_addr are valid.
- word_ready, input, 1, sink accepts the word.
- word_data, output, 16, encoded word.
- word_addr, output, ADDR_W, target address of word_data.
- word_last, output, 1, high on the final word of an instruction.
- err, output, 1, one-cycle pulse on a rejected request.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset: state=IDLE; address counter=0; word_valid, word_data, word_addr, word_last, err and busy all 0; req_ready=1 once reset is released.
- States: IDLE, WORD0, WORD1.
- IDLE:
  - On req_valid with a legal request: latch the operands, register the encoded first word, go to WORD0. word_valid rises the cycle after acceptance (latency 1).
  - On req_valid with an illegal request: err=1 for one cycle, stay in IDLE, counter unchanged.
  - A request is illegal if req_opcode is 0 or greater than 12, or if the opcode is LDI, SUBI or SBCI with req_rd<16.
- WORD0:
  - word_valid, word_data, word_addr and word_last are held stable until word_ready.
  - On acceptance the counter increments by 1.
  - JMP/CALL go to WORD1 with word_data=imm[15:0], presented the next cycle. All others go to IDLE.
- WORD1: held until word_ready; on acceptance the counter increments, then go to IDLE with word_valid=0.
- word_last: 0 in WORD0 for JMP/CALL; 1 otherwise.
- addr_load and req_valid in the same IDLE cycle: the load applies first, so the request's first word uses addr_value.
- The counter wraps modulo 2^ADDR_W with no flag.
- Encodings (K=imm[7:0]; d'=rd-16; fields are truncated, no range check beyond the d>=16 rule):
  - LDI: 1110 K[7:4] d'[3:0] K[3:0].
  - SUBI: 0101 K[7:4] d'[3:0] K[3:0].
  - SBCI: 0100 K[7:4] d'[3:0] K[3:0].
  - JMP: 1001 010 k[21:17] 110 k[16], then k[15:0].
  - CALL: 1001 010 k[21:17] 111 k[16], then k[15:0].
  - OUT: 1011 1 A[5:4] r[4:0] A[3:0], with A=imm[5:0].
  - RET: 0x9508. CLI: 0x94F8. NOP: 0x0000.
  - RJMP: 1100 imm[11:0], two's complement.
  - EOR: 0010 01 rr[4] rd[4:0] rr[3:0].
  - BRNE: 1111 01 imm[6:0] 001.
- Back-to-back: after the last word is accepted, IDLE is entered the next cycle, so at most one instruction is in flight.
- Reset mid-operation: the word is aborted immediately, the counter returns to 0, and nothing is emitted after release.

Test Plan:
- addr_load 0x0000; LDI rd=16 imm=0xFF -> one word 0xEF0F at addr 0x0000 with word_last=1; word_valid appears 1 cycle after acceptance.
- JMP imm=0x000034 -> 0x940C at addr 0, then 0x0034 at addr 1 with word_last=1. CALL imm=0x3FFFFF -> 0x95FF, then 0xFFFF.
- OUT rd=0 imm=0x3F with word_ready held low 3 cycles -> word_data stays 0xBE0F, word_addr stays stable and req_ready stays 0 until the handshake completes.
- BRNE imm=-2 -> 0xF7F1; RJMP imm=-1 -> 0xCFFF; EOR rd=1 rr=1 -> 0x2411; RET -> 0x9508; CLI -> 0x94F8; NOP -> 0x0000. Addresses increment by 1 per word.
- Opcode 0, opcode 13, and LDI rd=5 -> each gives an err pulse of exactly 1 cycle, no word_valid, counter unchanged.
- addr_load 0xFFFF then JMP -> words at 0xFFFF and 0x0000. Assert reset while in WORD1 -> word_valid drops to 0 asynchronously; after release, counter=0 and state is IDLE.
